io_bus_ctrl: RTL and testbench

Parametrised IO-class bus controller: the next generation of the flat IO chip-select decode and read-data mux.
- Decodes the IO device class into NUM_DEV one-hot selects.
- Stretches each access by a per-device wait-state count plus a device ready handshake.
- Returns registered read data with a single-cycle ack.
- Flags unmapped registers and hung devices with bus_error.
- Sits between the CPU bus and the IO peripherals (LED, PS/2, tonegen, I2C, UART, ...). Memory classes stay outside this block.

---
 rtl/bus_pkg.sv | 38 +++
 rtl/io_read_mux.sv | 26 ++
 rtl/io_bus_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_io_bus_ctrl.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the IO-class bus controller: defaults, FSM states
// and the register index of each IO peripheral.
package bus_pkg;

  localparam int unsigned NUM_DEV_DEFAULT    = 13;
  localparam int unsigned WAIT_WIDTH_DEFAULT = 4;
  localparam int unsigned TIMEOUT_DEFAULT    = 64;
  localparam logic [7:0]  IO_CLASS_DEFAULT   = 8'h0f;

  // Every device answers with zero minimum wait states unless overridden.
  localparam logic [NUM_DEV_DEFAULT*WAIT_WIDTH_DEFAULT-1:0] DEV_WAIT_DEFAULT = '0;

  // Register index field is address[7:2], so at most 64 devices.
  localparam int unsigned MAX_DEV = 64;
  localparam int unsigned IDX_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } bus_state_e;

  // Register index of each IO peripheral (address[7:2]).
  localparam int unsigned DEV_LED              = 0;
  localparam int unsigned DEV_PS2_STATUS       = 1;
  localparam int unsigned DEV_PS2_SCANCODE     = 2;
  localparam int unsigned DEV_TONEGEN_DURATION = 3;
  localparam int unsigned DEV_TONEGEN_PERIOD   = 4;
  localparam int unsigned DEV_I2C_CTRL         = 5;
  localparam int unsigned DEV_I2C_STATUS       = 6;
  localparam int unsigned DEV_I2C_TX           = 7;
  localparam int unsigned DEV_I2C_RX           = 8;
  localparam int unsigned DEV_UART_CTRL        = 9;
  localparam int unsigned DEV_UART_STATUS      = 10;
  localparam int unsigned DEV_UART_BAUD        = 11;
  localparam int unsigned DEV_UART_DATA        = 12;

endpackage

// File: rtl/io_read_mux.sv
// Combinational NUM_DEV:1 read-data select. Indices at or above NUM_DEV
// return zero so the select never reads outside the packed bus.
module io_read_mux
  import bus_pkg::*;
#(
  parameter int unsigned NUM_DEV = NUM_DEV_DEFAULT
) (
  input  logic [IDX_W-1:0]      sel,
  input  logic [32*NUM_DEV-1:0] dev_data,
  output logic [31:0]           rd_data
);

  logic [31:0] word_tbl [MAX_DEV];

  // Unpack the device bus into a full 64-entry table, zero-padded.
  for (genvar gi = 0; gi < MAX_DEV; gi++) begin : g_word
    if (gi < NUM_DEV) begin : g_dev
      assign word_tbl[gi] = dev_data[32*gi +: 32];
    end else begin : g_pad
      assign word_tbl[gi] = '0;
    end
  end

  assign rd_data = word_tbl[sel];

endmodule

// File: rtl/io_bus_ctrl.sv
// IO-class bus controller: decodes the register index into one-hot device
// selects, stretches each access by a per-device wait count plus the device
// ready handshake, returns registered read data with a one-cycle ack and
// flags unmapped registers or hung devices with bus_error.
module io_bus_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned                    NUM_DEV    = NUM_DEV_DEFAULT,
  parameter logic [7:0]                     IO_CLASS   = IO_CLASS_DEFAULT,
  parameter int unsigned                    WAIT_WIDTH = WAIT_WIDTH_DEFAULT,
  parameter logic [NUM_DEV*WAIT_WIDTH-1:0]  DEV_WAIT   = DEV_WAIT_DEFAULT,
  parameter int unsigned                    TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [29:0]           address,
  input  logic                  req,
  input  logic                  write,
  input  logic [NUM_DEV-1:0]    dev_ready,
  input  logic [32*NUM_DEV-1:0] dev_data,
  output logic [NUM_DEV-1:0]    dev_cs,
  output logic                  dev_write,
  output logic                  busy,
  output logic                  ack,
  output logic [31:0]           data_in,
  output logic                  bus_error
);

  localparam int unsigned     TO_W        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT - 1);
  localparam logic [IDX_W:0]  NUM_DEV_EXT = (IDX_W+1)'(NUM_DEV);

  // address is the word address [31:2]: class is byte bits [31:24],
  // register index is byte bits [7:2]; the bits between are don't-care.
  logic [7:0]       req_class;
  logic [IDX_W-1:0] req_idx;
  logic             req_mapped;
  logic             addr_unused;

  assign req_class   = address[29:22];
  assign req_idx     = address[IDX_W-1:0];
  assign req_mapped  = ({1'b0, req_idx} < NUM_DEV_EXT);
  assign addr_unused = ^address[21:IDX_W];

  // Per-index views padded to 64 entries so any 6-bit index is in range.
  logic [MAX_DEV-1:0]    ready_ext;
  logic [WAIT_WIDTH-1:0] wait_tbl [MAX_DEV];
  logic [NUM_DEV-1:0]    req_onehot;

  for (genvar gi = 0; gi < MAX_DEV; gi++) begin : g_tbl
    if (gi < NUM_DEV) begin : g_dev
      assign ready_ext[gi] = dev_ready[gi];
      assign wait_tbl[gi]  = DEV_WAIT[gi*WAIT_WIDTH +: WAIT_WIDTH];
    end else begin : g_pad
      assign ready_ext[gi] = 1'b0;
      assign wait_tbl[gi]  = '0;
    end
  end

  for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_dec
    assign req_onehot[gi] = (req_idx == IDX_W'(gi));
  end

  bus_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DEV-1:0]    dev_cs_q, dev_cs_d;
  logic                  dev_write_q, dev_write_d;
  logic [WAIT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;
  logic                  bus_error_q, bus_error_d;
  logic [31:0]           data_in_q, data_in_d;
  logic [31:0]           mux_data;
  logic                  complete;

  io_read_mux #(
    .NUM_DEV (NUM_DEV)
  ) u_read_mux (
    .sel      (idx_q),
    .dev_data (dev_data),
    .rd_data  (mux_data)
  );

  // The selected device is finished once its wait states are used up and it
  // reports ready; this beats the timeout when both happen together.
  assign complete = (wait_cnt_q == '0) && ready_ext[idx_q];

  // Next-state and registered-output computation for the access FSM.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dev_cs_d    = dev_cs_q;
    dev_write_d = dev_write_q;
    wait_cnt_d  = wait_cnt_q;
    to_cnt_d    = to_cnt_q;
    data_in_d   = data_in_q;
    ack_d       = 1'b0;
    bus_error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req && (req_class == IO_CLASS)) begin
          if (req_mapped) begin
            idx_d       = req_idx;
            dev_cs_d    = req_onehot;
            dev_write_d = write;
            wait_cnt_d  = wait_tbl[req_idx];
            to_cnt_d    = '0;
            state_d     = ST_WAIT;
          end else begin
            ack_d       = 1'b1;
            bus_error_d = 1'b1;
            data_in_d   = '0;
            state_d     = ST_DONE;
          end
        end
      end

      ST_WAIT: begin
        if (complete) begin
          ack_d       = 1'b1;
          data_in_d   = dev_write_q ? 32'h0 : mux_data;
          dev_cs_d    = '0;
          dev_write_d = 1'b0;
          state_d     = ST_DONE;
        end else begin
          if (wait_cnt_q != '0) begin
            wait_cnt_d = wait_cnt_q - WAIT_WIDTH'(1);
          end
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_q == TO_LAST) begin
            ack_d       = 1'b1;
            bus_error_d = 1'b1;
            data_in_d   = '0;
            dev_cs_d    = '0;
            dev_write_d = 1'b0;
            state_d     = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      dev_cs_q    <= '0;
      dev_write_q <= 1'b0;
      wait_cnt_q  <= '0;
      to_cnt_q    <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      bus_error_q <= 1'b0;
      data_in_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dev_cs_q    <= dev_cs_d;
      dev_write_q <= dev_write_d;
      wait_cnt_q  <= wait_cnt_d;
      to_cnt_q    <= to_cnt_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      bus_error_q <= bus_error_d;
      data_in_q   <= data_in_d;
    end
  end

  assign dev_cs    = dev_cs_q;
  assign dev_write = dev_write_q;
  assign busy      = busy_q;
  assign ack       = ack_q;
  assign bus_error = bus_error_q;
  assign data_in   = data_in_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Self-checking bench for io_bus_ctrl: directed scenarios plus randomized
// accesses compared against a cycle-count model of the access rules.
module tb_io_bus_ctrl;
  import bus_pkg::*;

  localparam int ND  = 13;
  localparam int TMO = 64;
  // Wait fields: dev4=3, dev6=2, dev7=5, dev9=1, all others 0.
  localparam logic [ND*4-1:0] WAITS = 52'h0001052030000;

  int wait_of [ND] = '{0, 0, 0, 0, 3, 0, 2, 5, 0, 1, 0, 0, 0};

  logic              clk = 1'b0;
  logic              rst;
  logic [29:0]       address;
  logic              req;
  logic              write;
  logic [ND-1:0]     dev_ready;
  logic [32*ND-1:0]  dev_data;
  logic [ND-1:0]     dev_cs;
  logic              dev_write;
  logic              busy;
  logic              ack;
  logic [31:0]       data_in;
  logic              bus_error;

  io_bus_ctrl #(
    .NUM_DEV    (ND),
    .IO_CLASS   (8'h0f),
    .WAIT_WIDTH (4),
    .DEV_WAIT   (WAITS),
    .TIMEOUT    (TMO)
  ) dut (
    .clock     (clk),
    .reset     (rst),
    .address   (address),
    .req       (req),
    .write     (write),
    .dev_ready (dev_ready),
    .dev_data  (dev_data),
    .dev_cs    (dev_cs),
    .dev_write (dev_write),
    .busy      (busy),
    .ack       (ack),
    .data_in   (data_in),
    .bus_error (bus_error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Observations of the last access (cycle 0 = cycle in which req is driven).
  int            obs_ack_cyc;
  logic [31:0]   obs_data;
  logic          obs_err;
  int            obs_cs_cycles;
  logic          obs_cs_bad;
  int            obs_wr_cycles;
  logic [ND-1:0] obs_cs_at_ack;
  logic          obs_wr_at_ack;
  logic          obs_busy_seen;
  logic [ND-1:0] exp_onehot;
  logic [31:0]   data_hist [0:255];

  // Drive one access and record what the DUT does; target dev_ready rises at
  // cycle ready_rise, other devices' ready and all data are random noise.
  task automatic run_access(input logic [29:0] addr, input logic wr,
                            input int ready_rise, input int bound);
    int dev;
    dev = int'(addr[5:0]);
    obs_ack_cyc   = -1;
    obs_data      = '0;
    obs_err       = 1'b0;
    obs_cs_cycles = 0;
    obs_cs_bad    = 1'b0;
    obs_wr_cycles = 0;
    obs_cs_at_ack = '0;
    obs_wr_at_ack = 1'b0;
    obs_busy_seen = 1'b0;
    exp_onehot    = '0;
    if (dev < ND) exp_onehot[dev] = 1'b1;
    for (int c = 0; c <= bound; c++) begin
      @(posedge clk); #1;
      if (c > 0) begin
        if (busy) obs_busy_seen = 1'b1;
        if (ack) begin
          obs_ack_cyc   = c;
          obs_data      = data_in;
          obs_err       = bus_error;
          obs_cs_at_ack = dev_cs;
          obs_wr_at_ack = dev_write;
          break;
        end
        if (dev_cs != '0) begin
          obs_cs_cycles++;
          if (dev_cs !== exp_onehot) obs_cs_bad = 1'b1;
          if (dev_write) obs_wr_cycles++;
        end
      end
      req       = (c == 0);
      address   = (c == 0) ? addr : 30'($urandom);
      write     = (c == 0) ? wr : 1'($urandom);
      dev_ready = ND'($urandom);
      if (dev < ND) dev_ready[dev] = (c >= ready_rise);
      for (int d = 0; d < ND; d++) dev_data[32*d +: 32] = $urandom;
      data_hist[c] = (dev < ND) ? dev_data[32*dev +: 32] : 32'h0;
    end
    req = 1'b0;
    $display("txn addr=%h wr=%0b ready_rise=%0d ack_cyc=%0d data=%h err=%0b cs_cycles=%0d",
             addr, wr, ready_rise, obs_ack_cyc, obs_data, obs_err, obs_cs_cycles);
  endtask

  // Reference timing: the access completes in the first cycle (counting the
  // first select cycle as 1) that is past the device's wait states and has
  // ready high; past TIMEOUT select cycles it is aborted with an error.
  function automatic void model(input logic [29:0] addr, input logic wr, input int ready_rise,
                                output int e_ack, output logic e_err,
                                output int e_cs, output int e_done);
    int dev, first;
    dev = int'(addr[5:0]);
    if (addr[29:22] != 8'h0f) begin
      e_ack = -1; e_err = 1'b0; e_cs = 0; e_done = -1;
    end else if (dev >= ND) begin
      e_ack = 1; e_err = 1'b1; e_cs = 0; e_done = -1;
    end else begin
      first = 1 + wait_of[dev];
      if (ready_rise > first) first = ready_rise;
      if (first <= TMO) begin
        e_ack = first + 1; e_err = 1'b0; e_cs = first; e_done = wr ? -1 : first;
      end else begin
        e_ack = TMO + 1; e_err = 1'b1; e_cs = TMO; e_done = -1;
      end
    end
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    req = 1'b1;
    address = 30'h03c00002;
    write = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (dev_cs !== '0) begin
      failures++; $display("FAIL reset_dev_cs: got %b expected 0", dev_cs);
    end
    checks++;
    if ({busy, ack, bus_error, dev_write} !== 4'b0) begin
      failures++; $display("FAIL reset_flags: got busy/ack/err/wr=%b expected 0000",
                           {busy, ack, bus_error, dev_write});
    end
    checks++;
    if (data_in !== 32'h0) begin
      failures++; $display("FAIL reset_data_in: got %h expected 0", data_in);
    end
    rst = 1'b0;
    req = 1'b0;
    $display("txn reset done");
  endtask

  task automatic test_basic_read;
    logic [31:0] b;
    b = 32'h0f000008;
    run_access(b[31:2], 1'b0, 0, 20);
    checks++;
    if (obs_ack_cyc !== 2) begin
      failures++; $display("FAIL read_ack_cycle: got %0d expected 2", obs_ack_cyc);
    end
    checks++;
    if (obs_data !== data_hist[1]) begin
      failures++; $display("FAIL read_data: got %h expected %h", obs_data, data_hist[1]);
    end
    checks++;
    if (obs_err !== 1'b0) begin
      failures++; $display("FAIL read_err: got %b expected 0", obs_err);
    end
    checks++;
    if (obs_cs_cycles !== 1 || obs_cs_bad !== 1'b0) begin
      failures++; $display("FAIL read_cs: got cycles=%0d bad=%b expected cycles=1 bad=0",
                           obs_cs_cycles, obs_cs_bad);
    end
    checks++;
    if (obs_cs_at_ack !== '0) begin
      failures++; $display("FAIL read_cs_at_ack: got %b expected 0", obs_cs_at_ack);
    end
  endtask

  task automatic test_wait_write;
    logic [31:0] b;
    b = 32'h0f000010;
    run_access(b[31:2], 1'b1, 0, 20);
    checks++;
    if (obs_ack_cyc !== 5) begin
      failures++; $display("FAIL wait_ack_cycle: got %0d expected 5", obs_ack_cyc);
    end
    checks++;
    if (obs_cs_cycles !== 4 || obs_wr_cycles !== 4 || obs_cs_bad !== 1'b0) begin
      failures++; $display("FAIL wait_cs_wr: got cs=%0d wr=%0d bad=%b expected cs=4 wr=4 bad=0",
                           obs_cs_cycles, obs_wr_cycles, obs_cs_bad);
    end
    checks++;
    if (obs_data !== 32'h0 || obs_err !== 1'b0) begin
      failures++; $display("FAIL wait_data_err: got data=%h err=%b expected 0/0", obs_data, obs_err);
    end
  endtask

  task automatic test_ready_handshake;
    logic [31:0] b;
    b = 32'h0f000004;
    run_access(b[31:2], 1'b0, 11, 40);
    checks++;
    if (obs_ack_cyc !== 12) begin
      failures++; $display("FAIL handshake_ack_cycle: got %0d expected 12", obs_ack_cyc);
    end
    checks++;
    if (obs_data !== data_hist[11]) begin
      failures++; $display("FAIL handshake_data: got %h expected %h", obs_data, data_hist[11]);
    end
    checks++;
    if (obs_cs_cycles !== 11) begin
      failures++; $display("FAIL handshake_cs_cycles: got %0d expected 11", obs_cs_cycles);
    end
  endtask

  task automatic test_reset_mid_access;
    logic [31:0] b;
    b = 32'h0f000010;
    @(posedge clk); #1;
    req = 1'b1; address = b[31:2]; write = 1'b1; dev_ready = '1;
    @(posedge clk); #1;
    req = 1'b0;
    checks++;
    if (dev_cs !== 13'b0000000010000) begin
      failures++; $display("FAIL midrst_cs_before: got %b expected 0000000010000", dev_cs);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (dev_cs !== '0 || busy !== 1'b0 || dev_write !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs: got cs=%b busy=%b wr=%b expected 0/0/0",
                           dev_cs, busy, dev_write);
    end
    checks++;
    if (ack !== 1'b0 || bus_error !== 1'b0 || data_in !== 32'h0) begin
      failures++; $display("FAIL midrst_ack_data: got ack=%b err=%b data=%h expected 0/0/0",
                           ack, bus_error, data_in);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL midrst_idle: got ack=%b busy=%b expected 0/0", ack, busy);
      end
    end
    $display("txn reset mid access");
    b = 32'h0f000008;
    run_access(b[31:2], 1'b0, 0, 20);
    checks++;
    if (obs_ack_cyc !== 2 || obs_data !== data_hist[1]) begin
      failures++; $display("FAIL midrst_fresh: got ack_cyc=%0d data=%h expected 2/%h",
                           obs_ack_cyc, obs_data, data_hist[1]);
    end
  endtask

  task automatic test_timeout;
    logic [31:0] b;
    b = 32'h0f000014;
    run_access(b[31:2], 1'b0, 64, 100);
    checks++;
    if (obs_ack_cyc !== 65 || obs_err !== 1'b0 || obs_data !== data_hist[64]) begin
      failures++; $display("FAIL timeout_edge_complete: got ack=%0d err=%b data=%h expected 65/0/%h",
                           obs_ack_cyc, obs_err, obs_data, data_hist[64]);
    end
    run_access(b[31:2], 1'b0, 1000, 100);
    checks++;
    if (obs_ack_cyc !== 65 || obs_err !== 1'b1) begin
      failures++; $display("FAIL timeout_stuck: got ack=%0d err=%b expected 65/1", obs_ack_cyc, obs_err);
    end
    checks++;
    if (obs_data !== 32'h0 || obs_cs_cycles !== 64 || obs_cs_at_ack !== '0) begin
      failures++; $display("FAIL timeout_state: got data=%h cs=%0d cs_ack=%b expected 0/64/0",
                           obs_data, obs_cs_cycles, obs_cs_at_ack);
    end
    run_access(b[31:2], 1'b0, 65, 100);
    checks++;
    if (obs_ack_cyc !== 65 || obs_err !== 1'b1) begin
      failures++; $display("FAIL timeout_late_ready: got ack=%0d err=%b expected 65/1",
                           obs_ack_cyc, obs_err);
    end
  endtask

  task automatic test_unmapped;
    logic [31:0] b;
    b = 32'h0f0000fc;
    run_access(b[31:2], 1'b0, 0, 20);
    checks++;
    if (obs_ack_cyc !== 1 || obs_err !== 1'b1 || obs_cs_cycles !== 0 || obs_data !== 32'h0) begin
      failures++; $display("FAIL unmapped_63: got ack=%0d err=%b cs=%0d data=%h expected 1/1/0/0",
                           obs_ack_cyc, obs_err, obs_cs_cycles, obs_data);
    end
    b = 32'h0f000034;
    run_access(b[31:2], 1'b1, 0, 20);
    checks++;
    if (obs_ack_cyc !== 1 || obs_err !== 1'b1) begin
      failures++; $display("FAIL unmapped_13: got ack=%0d err=%b expected 1/1", obs_ack_cyc, obs_err);
    end
    b = 32'h0f000030;
    run_access(b[31:2], 1'b0, 0, 20);
    checks++;
    if (obs_ack_cyc !== 2 || obs_err !== 1'b0) begin
      failures++; $display("FAIL mapped_12: got ack=%0d err=%b expected 2/0", obs_ack_cyc, obs_err);
    end
    b = 32'h01000000;
    run_access(b[31:2], 1'b0, 0, 8);
    checks++;
    if (obs_ack_cyc !== -1 || obs_busy_seen !== 1'b0) begin
      failures++; $display("FAIL other_class: got ack=%0d busy=%b expected -1/0",
                           obs_ack_cyc, obs_busy_seen);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] b;
    int acks;
    b = 32'h0f000008;
    acks = 0;
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c > 0) begin
        checks++;
        if (ack !== ((c % 3) == 2)) begin
          failures++; $display("FAIL b2b_ack_c%0d: got %b expected %b", c, ack, ((c % 3) == 2));
        end
        if (ack) begin
          acks++;
          checks++;
          if (data_in !== data_hist[c-1]) begin
            failures++; $display("FAIL b2b_data_c%0d: got %h expected %h", c, data_in, data_hist[c-1]);
          end
        end
      end
      req = (c < 12);
      address = b[31:2];
      write = 1'b0;
      dev_ready = '1;
      for (int d = 0; d < ND; d++) dev_data[32*d +: 32] = $urandom;
      data_hist[c] = dev_data[64 +: 32];
    end
    req = 1'b0;
    checks++;
    if (acks !== 4) begin
      failures++; $display("FAIL b2b_ack_count: got %0d expected 4", acks);
    end
    $display("txn back_to_back acks=%0d", acks);
  endtask

  task automatic test_random;
    logic [7:0]  cls;
    logic [5:0]  idx;
    logic [29:0] addr;
    logic        wr;
    int kind, rr, e_ack, e_cs, e_done;
    logic e_err;
    logic [31:0] e_data;
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 9);
      cls = 8'h0f;
      if (kind == 1) begin
        do cls = 8'($urandom); while (cls == 8'h0f);
      end
      idx  = (kind == 0) ? 6'($urandom_range(13, 63)) : 6'($urandom_range(0, 12));
      addr = {cls, 16'($urandom), idx};
      wr   = 1'($urandom);
      rr   = $urandom_range(0, 12);
      model(addr, wr, rr, e_ack, e_err, e_cs, e_done);
      run_access(addr, wr, rr, (cls == 8'h0f) ? 100 : 6);
      e_data = (e_done < 0) ? 32'h0 : data_hist[e_done];
      checks++;
      if (obs_ack_cyc !== e_ack || obs_err !== e_err) begin
        failures++; $display("FAIL rand%0d_ack: got ack=%0d err=%b expected %0d/%b",
                             t, obs_ack_cyc, obs_err, e_ack, e_err);
      end
      if (e_ack > 0) begin
        checks++;
        if (obs_data !== e_data) begin
          failures++; $display("FAIL rand%0d_data: got %h expected %h", t, obs_data, e_data);
        end
        checks++;
        if (obs_cs_cycles !== e_cs || obs_cs_bad !== 1'b0 || obs_cs_at_ack !== '0) begin
          failures++; $display("FAIL rand%0d_cs: got cs=%0d bad=%b cs_ack=%b expected %0d/0/0",
                               t, obs_cs_cycles, obs_cs_bad, obs_cs_at_ack, e_cs);
        end
        checks++;
        if (obs_wr_cycles !== (wr ? e_cs : 0) || obs_wr_at_ack !== 1'b0) begin
          failures++; $display("FAIL rand%0d_wr: got wr=%0d wr_ack=%b expected %0d/0",
                               t, obs_wr_cycles, obs_wr_at_ack, wr ? e_cs : 0);
        end
      end else begin
        checks++;
        if (obs_busy_seen !== 1'b0) begin
          failures++; $display("FAIL rand%0d_ignored_busy: got %b expected 0", t, obs_busy_seen);
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req       = 1'b0;
    address   = '0;
    write     = 1'b0;
    dev_ready = '1;
    dev_data  = '0;
    test_reset;
    test_basic_read;
    test_wait_write;
    test_ready_handshake;
    test_reset_mid_access;
    test_timeout;
    test_unmapped;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
